// File: rtl/dcache_assoc.sv
// ---------------------------------------------------------------------------
// dcache_assoc : N-way set-associative, write-back, write-allocate data cache
//                with LRU replacement, sitting between the MEM stage and a
//                block-wide data memory. Hits are served combinationally; a
//                miss stalls the CPU while a dirty victim is written back and
//                the block is refilled. All state updates on negedge CLOCK.
//
// Ports:
//   CLOCK, RESET                 clock, synchronous active-high reset
//   READ_EN, WRITE_EN            CPU load/store request (both high = store)
//   address, WRITE_DATA          CPU byte address and store data
//   READ_DATA, BUSYWAIT          load data (0 unless hit) and CPU stall
//   mem_read, mem_write          block read / write request to memory
//   mem_address                  block address {tag, index}
//   mem_WRITE_DATA               victim block (word0 in LSBs)
//   mem_READ_DATA, mem_busywait  fetched block and memory busy flag
//
// Optional feature (macro DCACHE_STATS_EN): adds hit_count, miss_count and
// wb_count 32-bit event counters. Undefined by default.
// ---------------------------------------------------------------------------
module dcache_assoc #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    parameter int SETS   = 8,
    parameter int WAYS   = 2
) (
    input  logic                                   CLOCK,
    input  logic                                   RESET,
    input  logic                                   READ_EN,
    input  logic                                   WRITE_EN,
    input  logic [ADDR_W-1:0]                      address,
    input  logic [DATA_W-1:0]                      WRITE_DATA,
    output logic [DATA_W-1:0]                      READ_DATA,
    output logic                                   BUSYWAIT,
    output logic                                   mem_read,
    output logic                                   mem_write,
    output logic [ADDR_W-$clog2(WORDS)-2-1:0]      mem_address,
    output logic [DATA_W*WORDS-1:0]                mem_WRITE_DATA,
    input  logic [DATA_W*WORDS-1:0]                mem_READ_DATA,
    input  logic                                   mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]                            hit_count,
    output logic [31:0]                            miss_count,
    output logic [31:0]                            wb_count
`endif
);

    localparam int OFF    = $clog2(WORDS) + 2;
    localparam int IDX    = $clog2(SETS);
    localparam int TAG    = ADDR_W - IDX - OFF;
    localparam int WORD_W = $clog2(WORDS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BLK_W  = DATA_W * WORDS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;

    state_t             state_q;
    logic [WAY_W-1:0]   victim_q;
    logic [BLK_W-1:0]   fill_q;

    logic               valid_q [WAYS][SETS];
    logic               dirty_q [WAYS][SETS];
    logic [TAG-1:0]     tag_q   [WAYS][SETS];
    logic [BLK_W-1:0]   data_q  [WAYS][SETS];
    // Age 0 = MRU. With WAYS == 1 the ages never change and fold away.
    logic [WAY_W-1:0]   age_q   [WAYS][SETS];

    logic               req;
    logic [WORD_W-1:0]  word;
    logic [IDX-1:0]     idx;
    logic [TAG-1:0]     tag;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   vict_way;
    logic               found_inv;
    logic [WAY_W-1:0]   oldest;
    logic               mru_en;
    logic [WAY_W-1:0]   mru_way;
    logic [BLK_W-1:0]   fill_merged;
    logic               unused_addr;

    assign req         = READ_EN | WRITE_EN;
    assign word        = address[OFF-1:2];
    assign idx         = address[OFF+IDX-1:OFF];
    assign tag         = address[ADDR_W-1:OFF+IDX];
    assign unused_addr = ^address[1:0];

    // Tag match across the indexed set; at most one way can match.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, else the oldest way.
    always_comb begin
        found_inv = 1'b0;
        vict_way  = '0;
        oldest    = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!valid_q[w][idx] && !found_inv) begin
                found_inv = 1'b1;
                vict_way  = WAY_W'(w);
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (age_q[w][idx] > age_q[oldest][idx]) begin
                oldest = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            vict_way = oldest;
        end
    end

    // Refill block with the pending store merged in.
    always_comb begin
        fill_merged = fill_q;
        if (WRITE_EN) begin
            fill_merged[word*DATA_W +: DATA_W] = WRITE_DATA;
        end
    end

    assign mru_en  = ((state_q == IDLE) && req && hit) || (state_q == FILL);
    assign mru_way = (state_q == FILL) ? victim_q : hit_way;

    assign READ_DATA = (req && hit) ? data_q[hit_way][idx][word*DATA_W +: DATA_W] : '0;

    // Memory-side outputs and stall decoded from the current state.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_WRITE_DATA = '0;
        BUSYWAIT       = 1'b1;
        case (state_q)
            IDLE: BUSYWAIT = req & ~hit;
            WRITEBACK: begin
                mem_write      = 1'b1;
                mem_address    = {tag_q[victim_q][idx], idx};
                mem_WRITE_DATA = data_q[victim_q][idx];
            end
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = address[ADDR_W-1:OFF];
            end
            default: ;
        endcase
    end

    always_ff @(negedge CLOCK) begin
        if (RESET) begin
            state_q  <= IDLE;
            victim_q <= '0;
            fill_q   <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[w][s]   <= WAY_W'(w);
                end
            end
`ifdef DCACHE_STATS_EN
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        if (WRITE_EN) begin
                            data_q[hit_way][idx][word*DATA_W +: DATA_W] <= WRITE_DATA;
                            dirty_q[hit_way][idx] <= 1'b1;
                        end
`ifdef DCACHE_STATS_EN
                        hit_count <= hit_count + 32'd1;
`endif
                    end else if (req) begin
                        victim_q <= vict_way;
                        state_q  <= (valid_q[vict_way][idx] && dirty_q[vict_way][idx])
                                    ? WRITEBACK : FETCH;
`ifdef DCACHE_STATS_EN
                        miss_count <= miss_count + 32'd1;
`endif
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state_q <= FETCH;
`ifdef DCACHE_STATS_EN
                        wb_count <= wb_count + 32'd1;
`endif
                    end
                end
                FETCH: begin
                    if (!mem_busywait) begin
                        fill_q  <= mem_READ_DATA;
                        state_q <= FILL;
                    end
                end
                default: begin
                    data_q[victim_q][idx]  <= fill_merged;
                    tag_q[victim_q][idx]   <= tag;
                    valid_q[victim_q][idx] <= 1'b1;
                    dirty_q[victim_q][idx] <= WRITE_EN;
                    state_q                <= IDLE;
                end
            endcase

            // Promote the touched way to MRU; younger ways age by one.
            if (mru_en && (WAYS > 1)) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == mru_way) begin
                        age_q[w][idx] <= '0;
                    end else if (age_q[w][idx] < age_q[mru_way][idx]) begin
                        age_q[w][idx] <= age_q[w][idx] + WAY_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// ---------------------------------------------------------------------------
// tb_dcache_assoc : self-checking bench for dcache_assoc (default parameters).
// A behavioural cache model (per-set MRU-first way order lists) and a separate
// reference memory predict hit/miss, victims, writeback traffic, stall length
// and load data. Define DCACHE_STATS_EN to also check the event counters.
// ---------------------------------------------------------------------------
module tb_dcache_assoc;

    localparam int SETS  = 8;
    localparam int WAYS  = 2;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b1;
    logic         READ_EN = 1'b0;
    logic         WRITE_EN = 1'b0;
    logic [31:0]  address = '0;
    logic [31:0]  WRITE_DATA = '0;
    logic [31:0]  READ_DATA;
    logic         BUSYWAIT;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_WRITE_DATA;
    logic [127:0] mem_READ_DATA = '0;
    logic         mem_busywait = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count, miss_count, wb_count;
`endif

    dcache_assoc dut (
        .CLOCK(CLOCK), .RESET(RESET), .READ_EN(READ_EN), .WRITE_EN(WRITE_EN),
        .address(address), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA),
        .BUSYWAIT(BUSYWAIT), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_WRITE_DATA(mem_WRITE_DATA),
        .mem_READ_DATA(mem_READ_DATA), .mem_busywait(mem_busywait)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- memory: DUT-side and reference copies ----------------
    logic [127:0] mem_dut [int];
    logic [127:0] mem_ref [int];
    int mem_lat = 0;
    int mcnt    = 0;

    function automatic logic [127:0] blk_default(input logic [27:0] b);
        return {b, 4'h3, b, 4'h2, b, 4'h1, b, 4'h0};
    endfunction

    // Busy for mem_lat cycles, then one ready cycle that completes the access.
    always @(posedge CLOCK) begin
        if (mem_read || mem_write) begin
            if (mcnt < mem_lat) begin
                mem_busywait = 1'b1;
                mcnt++;
            end else begin
                mem_busywait = 1'b0;
                mcnt = 0;
                if (mem_write) mem_dut[int'(mem_address)] = mem_WRITE_DATA;
                else if (mem_dut.exists(int'(mem_address))) mem_READ_DATA = mem_dut[int'(mem_address)];
                else mem_READ_DATA = blk_default(mem_address);
            end
        end else begin
            mem_busywait = 1'b0;
            mcnt = 0;
        end
    end

    // ---------------- behavioural cache model ----------------
    logic         m_valid [SETS][WAYS];
    logic         m_dirty [SETS][WAYS];
    logic [24:0]  m_tag   [SETS][WAYS];
    logic [127:0] m_data  [SETS][WAYS];
    int           m_order [SETS][WAYS];   // MRU first
    int exp_hits, exp_miss, exp_wb;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_order[s][w] = w;
            end
        exp_hits = 0; exp_miss = 0; exp_wb = 0;
    endtask

    task automatic touch(input int s, input int w);
        int p;
        p = 0;
        for (int q = 0; q < WAYS; q++) if (m_order[s][q] == w) p = q;
        for (int q = p; q > 0; q--) m_order[s][q] = m_order[s][q-1];
        m_order[s][0] = w;
    endtask

    task automatic apply_reset();
        @(posedge CLOCK);
        RESET = 1'b1; READ_EN = 1'b0; WRITE_EN = 1'b0;
        @(negedge CLOCK); #1;
        RESET = 1'b0;
        model_reset();
    endtask

    // One CPU access, checked cycle by cycle against the model.
    task automatic do_access(input bit wr, input bit both, input logic [31:0] a,
                             input logic [31:0] wd, input int lat, input string name);
        int s, wi, hw, vic, cyc, busy_cycles, exp_busy;
        logic [24:0] t;
        bit ehit, ewb, saw_rd, saw_wr, both_hi;
        logic [27:0] exp_wbaddr, got_rdaddr, got_wraddr;
        logic [127:0] exp_wbdata, got_wrdata, blk;
        s = int'(a[6:4]); wi = int'(a[3:2]); t = a[31:7];
        ehit = 0; hw = 0; vic = -1; ewb = 0;
        exp_wbaddr = '0; exp_wbdata = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) begin ehit = 1; hw = w; end
        if (!ehit) begin
            for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && vic < 0) vic = w;
            if (vic < 0) vic = m_order[s][WAYS-1];
            ewb = m_valid[s][vic] && m_dirty[s][vic];
            exp_wbaddr = {m_tag[s][vic], a[6:4]};
            exp_wbdata = m_data[s][vic];
        end
        mem_lat = lat;
        @(posedge CLOCK);
        READ_EN = !wr || both; WRITE_EN = wr; address = a; WRITE_DATA = wd;
        #1;
        n_checks++;
        if (BUSYWAIT !== !ehit) begin
            n_fail++;
            $display("FAIL %s busywait: got %b want %b", name, BUSYWAIT, !ehit);
        end
        if (ehit) begin
            n_checks++;
            if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hit_mem_idle: got rd=%b wr=%b want 0 0", name, mem_read, mem_write);
            end
            if (!wr) begin
                n_checks++;
                if (READ_DATA !== m_data[s][hw][wi*32 +: 32]) begin
                    n_fail++;
                    $display("FAIL %s hit_data: got %h want %h", name, READ_DATA, m_data[s][hw][wi*32 +: 32]);
                end
            end
            if (wr) begin
                m_data[s][hw][wi*32 +: 32] = wd;
                m_dirty[s][hw] = 1'b1;
            end
            touch(s, hw);
            exp_hits++;
        end else begin
            cyc = 0; busy_cycles = 1; saw_rd = 0; saw_wr = 0; both_hi = 0;
            got_rdaddr = '0; got_wraddr = '0; got_wrdata = '0;
            while (BUSYWAIT === 1'b1 && cyc < 200) begin
                @(posedge CLOCK); #1;
                cyc++;
                if (mem_read && mem_write) both_hi = 1;
                if (mem_read && !saw_rd) begin saw_rd = 1; got_rdaddr = mem_address; end
                if (mem_write && !saw_wr) begin saw_wr = 1; got_wraddr = mem_address; got_wrdata = mem_WRITE_DATA; end
                if (BUSYWAIT === 1'b1) busy_cycles++;
            end
            exp_busy = 3 + lat + (ewb ? lat + 1 : 0);
            n_checks++;
            if (cyc >= 200) begin
                n_fail++;
                $display("FAIL %s timeout: busywait still %b after %0d cycles, want 0", name, BUSYWAIT, cyc);
            end
            n_checks++;
            if (both_hi) begin
                n_fail++;
                $display("FAIL %s rd_wr_overlap: got 1 want 0", name);
            end
            n_checks++;
            if (busy_cycles != exp_busy) begin
                n_fail++;
                $display("FAIL %s stall_len: got %0d want %0d", name, busy_cycles, exp_busy);
            end
            n_checks++;
            if (saw_wr != ewb) begin
                n_fail++;
                $display("FAIL %s writeback_seen: got %b want %b", name, saw_wr, ewb);
            end
            if (ewb && saw_wr) begin
                n_checks++;
                if (got_wraddr !== exp_wbaddr || got_wrdata !== exp_wbdata) begin
                    n_fail++;
                    $display("FAIL %s wb_block: got %h/%h want %h/%h", name, got_wraddr, got_wrdata, exp_wbaddr, exp_wbdata);
                end
            end
            n_checks++;
            if (!saw_rd || got_rdaddr !== a[31:4]) begin
                n_fail++;
                $display("FAIL %s fetch_addr: got %b/%h want 1/%h", name, saw_rd, got_rdaddr, a[31:4]);
            end
            if (ewb) mem_ref[int'(exp_wbaddr)] = exp_wbdata;
            blk = mem_ref.exists(int'(a[31:4])) ? mem_ref[int'(a[31:4])] : blk_default(a[31:4]);
            if (wr) blk[wi*32 +: 32] = wd;
            m_data[s][vic] = blk; m_tag[s][vic] = t;
            m_valid[s][vic] = 1'b1; m_dirty[s][vic] = wr;
            touch(s, vic);
            exp_miss++; exp_hits++;
            if (ewb) exp_wb++;
            n_checks++;
            if (READ_DATA !== blk[wi*32 +: 32]) begin
                n_fail++;
                $display("FAIL %s refill_data: got %h want %h", name, READ_DATA, blk[wi*32 +: 32]);
            end
        end
        @(negedge CLOCK); #1;
        READ_EN = 1'b0; WRITE_EN = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET = 1'b1; READ_EN = 1'b0; WRITE_EN = 1'b0;
        @(negedge CLOCK); @(negedge CLOCK); #1;
        n_checks++;
        if (BUSYWAIT !== 1'b0 || READ_DATA !== '0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got bw=%b rd=%h mr=%b mw=%b want all 0", BUSYWAIT, READ_DATA, mem_read, mem_write);
        end
        n_checks++;
        if (mem_address !== '0 || mem_WRITE_DATA !== '0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_address, mem_WRITE_DATA);
        end
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_cold_read();
        mem_dut[4] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        mem_ref[4] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        do_access(0, 0, 32'h40, '0, 3, "cold_read_40");
    endtask

    task automatic test_write_hit();
        do_access(1, 0, 32'h44, 32'hCAFEBABE, 1, "write_hit_44");
        do_access(0, 0, 32'h44, '0, 1, "read_back_44");
    endtask

    task automatic test_hit_sequence();
        do_access(0, 0, 32'hC0, '0, 2, "seq_read_C0");
        do_access(0, 0, 32'h40, '0, 2, "seq_read_40");
        do_access(0, 0, 32'hC0, '0, 2, "seq_reread_C0");
    endtask

    task automatic test_writeback();
        do_access(1, 1, 32'hC4, 32'h12345678, 2, "wb_write_C4");
        do_access(0, 0, 32'h40, '0, 2, "wb_read_40");
        do_access(0, 0, 32'h140, '0, 2, "wb_read_140");
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        n_checks++;
        if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_miss) || wb_count !== 32'(exp_wb)) begin
            n_fail++;
            $display("FAIL stats_counts: got %0d/%0d/%0d want %0d/%0d/%0d",
                     hit_count, miss_count, wb_count, exp_hits, exp_miss, exp_wb);
        end
        apply_reset();
        n_checks++;
        if (hit_count !== '0 || miss_count !== '0 || wb_count !== '0) begin
            n_fail++;
            $display("FAIL stats_reset: got %0d/%0d/%0d want 0/0/0", hit_count, miss_count, wb_count);
        end
    endtask
`endif

    task automatic test_reset_fetch();
        int cyc;
        apply_reset();
        mem_lat = 6;
        @(posedge CLOCK);
        READ_EN = 1'b1; address = 32'h40;
        cyc = 0;
        do begin
            @(posedge CLOCK); #1;
            cyc++;
        end while (mem_read !== 1'b1 && cyc < 20);
        n_checks++;
        if (mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_fetch_start: got mem_read=%b want 1", mem_read);
        end
        RESET = 1'b1; READ_EN = 1'b0;
        @(negedge CLOCK); #1;
        n_checks++;
        if (mem_read !== 1'b0 || BUSYWAIT !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fetch_abort: got mr=%b bw=%b want 0 0", mem_read, BUSYWAIT);
        end
        RESET = 1'b0;
        model_reset();
        do_access(0, 0, 32'h40, '0, 1, "post_reset_40");
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit wr;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            a = {23'($urandom_range(0, 3)), 3'($urandom_range(0, 7) & ((i < 150) ? 1 : 7)),
                 2'($urandom_range(0, 3)), 2'b00};
            wr = 1'($urandom_range(0, 1));
            do_access(wr, 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_hit_sequence();
        test_writeback();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        test_reset_fetch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache between the pipeline MEM stage and the block-wide data memory. It generalises the direct-mapped data cache in block size, set count, associativity and address width, and adds LRU replacement.
A hit is served combinationally with no stall. A miss stalls the CPU via BUSYWAIT while the controller writes back a dirty victim and then refills the block.

Parameters:
ADDR_W, 32, CPU byte-address width
DATA_W, 32, word width
WORDS, 4, words per block (power of 2, >=2)
SETS, 8, number of sets (power of 2)
WAYS, 2, associativity (1, 2 or 4)

Ports:
CLOCK  in  1  clock; all state updates on negedge CLOCK
RESET  in  1  synchronous, active-high reset
READ_EN  in  1  CPU load request
WRITE_EN  in  1  CPU store request
address  in  ADDR_W  CPU byte address
WRITE_DATA  in  DATA_W  store data
READ_DATA  out  DATA_W  load data
BUSYWAIT  out  1  CPU stall
mem_read  out  1  memory block read request
mem_write  out  1  memory block write request
mem_address  out  ADDR_W-OFF  memory block address
mem_WRITE_DATA  out  DATA_W*WORDS  victim block, word0 in LSBs
mem_READ_DATA  in  DATA_W*WORDS  fetched block, word0 in LSBs
mem_busywait  in  1  memory busy

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Address split:
  - OFF = log2(WORDS)+2; IDX = log2(SETS); TAG = ADDR_W-IDX-OFF.
  - address[1:0] ignored; word = address[OFF-1:2]; index = address[OFF+IDX-1:OFF]; tag = upper TAG bits.
- Per way per set: valid, dirty, tag, WORDS data words, log2(WAYS)-bit LRU age (0 = MRU).
- Hit: valid and tag equal in some way of the indexed set. At most one way can match.
- Request handling:
  - Request = READ_EN | WRITE_EN. If both are high, the access is a write.
  - The CPU holds address, WRITE_DATA and enables stable while BUSYWAIT is high.
- READ_DATA:
  - Combinational word from the hit way.
  - 0 when there is no hit or no request.
- Hit behaviour:
  - BUSYWAIT is 0 in the same cycle.
  - A write hit updates the word and sets dirty at the next edge.
  - Any hit makes that way MRU: its age goes to 0, and ages below its old age increment.
- Victim selection, combinational in IDLE:
  - Lowest-index invalid way if one exists.
  - Otherwise the way with maximum age.
- FSM states: IDLE, WRITEBACK, FETCH, FILL.
  - IDLE:
    - Outputs: mem_read=0, mem_write=0, mem_address=0, mem_WRITE_DATA=0.
    - BUSYWAIT = request & !hit, asserted combinationally in the miss cycle.
    - On a miss: go to WRITEBACK if the victim is valid & dirty, else to FETCH. The victim way is latched.
  - WRITEBACK:
    - Outputs: mem_write=1, mem_address={victim tag, index}, mem_WRITE_DATA=victim block, BUSYWAIT=1.
    - When mem_busywait=0, go to FETCH.
  - FETCH:
    - Outputs: mem_read=1, mem_address=address[ADDR_W-1:OFF], BUSYWAIT=1.
    - When mem_busywait=0, capture mem_READ_DATA into the fill buffer and go to FILL.
  - FILL:
    - BUSYWAIT=1; memory outputs as in IDLE.
    - At the edge: the victim way gets the fill block, tag, valid=1, dirty=0, and becomes MRU.
    - If WRITE_EN: the addressed word is replaced by WRITE_DATA and dirty=1.
    - Then go to IDLE. The next cycle is a hit, so BUSYWAIT drops.
- Latency:
  - Clean miss = 2 + memory cycles.
  - Dirty miss adds the writeback memory cycles.
  - mem_read and mem_write are never high together.
- Reset:
  - FSM goes to IDLE; all valid, dirty and fill-buffer state cleared.
  - Ages reset to way index, so way WAYS-1 is LRU.
  - All outputs are 0 after the reset edge.
  - Reset mid-WRITEBACK or mid-FETCH aborts the transaction; dirty data is discarded. Memory must tolerate a dropped request.
- WAYS=1 degenerates to direct-mapped with no age storage.

Optional Feature:
DCACHE_STATS_EN:
- When defined, adds three outputs: hit_count, miss_count, wb_count (32 bits each).
- hit_count increments on each IDLE-cycle edge with a request and a hit.
- miss_count increments on each IDLE-to-WRITEBACK or IDLE-to-FETCH transition.
- wb_count increments on the WRITEBACK-to-FETCH transition.
- All counters clear on RESET and wrap at 2^32.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
All scenarios use defaults; addresses 0x40, 0xC0 and 0x140 all map to index 4, with tags 0, 1 and 2.
- Cold read 0x40, memory busy 3 cycles, block word0=0x11111111 -> BUSYWAIT in the same cycle; mem_read=1 with mem_address=0x0000004; no mem_write; after FILL, READ_DATA=0x11111111 and BUSYWAIT=0.
- Write 0x44=0xCAFEBABE after the previous fill -> BUSYWAIT stays 0; the following read of 0x44 returns 0xCAFEBABE with no memory request.
- Read 0xC0, then 0x40, then 0xC0 -> only the 0xC0 first access misses; the second and third accesses hit with no mem_read.
- Write 0xC4=0x12345678, read 0x40, then read 0x140 -> victim is the 0xC0 way; mem_write with mem_address=0x000000C and mem_WRITE_DATA[63:32]=0x12345678; then mem_read with mem_address=0x0000014.
- RESET during FETCH -> at the next edge mem_read=0 and BUSYWAIT=0; a subsequent read of 0x40 misses.
- With DCACHE_STATS_EN, run the previous sequence -> hit_count, miss_count and wb_count match the scoreboard; all three are 0 after RESET.
